// File: rtl/tmp_pkg.sv
// Shared types and constants for the test-mode-persistence (TMP) controller.
package tmp_pkg;

  localparam int unsigned CNT_W                  = 8;
  localparam int unsigned RELEASE_CYCLES_DEFAULT = 4;

  typedef enum logic [1:0] {
    OFF       = 2'd0,
    ARMED     = 2'd1,
    ON        = 2'd2,
    RELEASING = 2'd3
  } tmp_fsm_e;

endpackage : tmp_pkg

// File: rtl/tmp_controller.sv
// TMP controller: holds test mode on across TAP resets until a clamp release
// has been followed by RELEASE_CYCLES Run-Test/Idle cycles.
module tmp_controller
  import tmp_pkg::*;
#(
  parameter int unsigned RELEASE_CYCLES = RELEASE_CYCLES_DEFAULT
) (
  input  logic TCK,
  input  logic TRST,
  input  logic test_logic_reset,
  input  logic run_test_idle,
  input  logic update_ir,
  input  logic clamp_hold_sel,
  input  logic clamp_release_sel,
  input  logic bypass_escape,
  output logic tmp_state,
  output logic release_busy,
  output logic escape_used
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RELEASE_CYCLES - 1);

  tmp_fsm_e         r_state;
  tmp_fsm_e         w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             r_escape_used;
  logic             w_escape_nxt;
  logic             r_tmp_state;
  logic             r_release_busy;

  // State, counter and output registers; outputs are loaded from next state
  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      r_state        <= OFF;
      r_count        <= '0;
      r_escape_used  <= 1'b0;
      r_tmp_state    <= 1'b0;
      r_release_busy <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_count        <= w_count_nxt;
      r_escape_used  <= w_escape_nxt;
      r_tmp_state    <= (w_state_nxt == ON) || (w_state_nxt == RELEASING);
      r_release_busy <= (w_state_nxt == RELEASING);
    end
  end

  // Next state; priority is test_logic_reset > update_ir > run_test_idle
  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_escape_nxt = r_escape_used;

    unique case (r_state)
      OFF: begin
        if (!test_logic_reset && update_ir && clamp_hold_sel) w_state_nxt = ARMED;
      end
      ARMED: begin
        if (test_logic_reset)                     w_state_nxt = OFF;
        else if (update_ir && !clamp_hold_sel)    w_state_nxt = OFF;
        else if (!update_ir && run_test_idle)     w_state_nxt = ON;
      end
      ON: begin
        if (test_logic_reset) begin
          if (bypass_escape) w_escape_nxt = 1'b1;
          else               w_state_nxt  = OFF;
        end else if (update_ir && clamp_release_sel && !clamp_hold_sel) begin
          w_state_nxt = RELEASING;
          w_count_nxt = '0;
        end
      end
      RELEASING: begin
        if (test_logic_reset) begin
          w_state_nxt = OFF;
        end else if (update_ir) begin
          if (clamp_hold_sel) w_state_nxt = ON;
        end else if (run_test_idle) begin
          if (r_count == LAST_CNT) w_state_nxt = OFF;
          else                     w_count_nxt = r_count + CNT_W'(1);
        end
      end
      default: w_state_nxt = OFF;
    endcase

    // Counter rests at zero outside a release; entering OFF drops the escape flag
    if (w_state_nxt != RELEASING) w_count_nxt  = '0;
    if (w_state_nxt == OFF)       w_escape_nxt = 1'b0;
  end

  assign tmp_state    = r_tmp_state;
  assign release_busy = r_release_busy;
  assign escape_used  = r_escape_used;

endmodule : tmp_controller

// File: tb/tb_tmp_controller.sv
// Directed bench for tmp_controller: one instance at RELEASE_CYCLES=4, one at 1.
module tb_tmp_controller;

  logic TCK = 1'b0;
  logic TRST;
  logic test_logic_reset, run_test_idle, update_ir;
  logic clamp_hold_sel, clamp_release_sel, bypass_escape;
  logic tmp_state, release_busy, escape_used;
  logic tmp_state1, release_busy1, escape_used1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 TCK = ~TCK;

  tmp_controller #(.RELEASE_CYCLES(4)) u_dut (
    .TCK(TCK), .TRST(TRST),
    .test_logic_reset(test_logic_reset), .run_test_idle(run_test_idle),
    .update_ir(update_ir), .clamp_hold_sel(clamp_hold_sel),
    .clamp_release_sel(clamp_release_sel), .bypass_escape(bypass_escape),
    .tmp_state(tmp_state), .release_busy(release_busy), .escape_used(escape_used)
  );

  tmp_controller #(.RELEASE_CYCLES(1)) u_dut1 (
    .TCK(TCK), .TRST(TRST),
    .test_logic_reset(test_logic_reset), .run_test_idle(run_test_idle),
    .update_ir(update_ir), .clamp_hold_sel(clamp_hold_sel),
    .clamp_release_sel(clamp_release_sel), .bypass_escape(bypass_escape),
    .tmp_state(tmp_state1), .release_busy(release_busy1), .escape_used(escape_used1)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of TAP inputs, then return 1 time unit after the edge
  task automatic cyc(input logic tlr, input logic rti, input logic uir,
                     input logic hold, input logic rel, input logic esc);
    test_logic_reset  = tlr;
    run_test_idle     = rti;
    update_ir         = uir;
    clamp_hold_sel    = hold;
    clamp_release_sel = rel;
    bypass_escape     = esc;
    @(posedge TCK);
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic go_on();
    cyc(0, 0, 1, 1, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
  endtask

  initial begin
    TRST = 1'b0;
    test_logic_reset = 0; run_test_idle = 0; update_ir = 0;
    clamp_hold_sel = 0; clamp_release_sel = 0; bypass_escape = 0;
    #1;
    chk("reset_tmp", 8'(tmp_state), 8'd0);
    chk("reset_busy", 8'(release_busy), 8'd0);
    chk("reset_esc", 8'(escape_used), 8'd0);
    @(posedge TCK); #1;
    TRST = 1'b1;

    // Hold entry: no rise until a Run-Test/Idle cycle has been spent in ARMED
    cyc(0, 0, 1, 1, 0, 0);
    chk("armed_tmp", 8'(tmp_state), 8'd0);
    idle();
    chk("armed_wait_tmp", 8'(tmp_state), 8'd0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("on_tmp", 8'(tmp_state), 8'd1);
    chk("on_busy", 8'(release_busy), 8'd0);

    // Release with gaps between Run-Test/Idle cycles
    cyc(0, 0, 1, 0, 1, 0);
    chk("rel_start_busy", 8'(release_busy), 8'd1);
    chk("rel_start_cnt", u_dut.r_count, 8'd0);
    for (int k = 1; k <= 4; k++) begin
      idle(); idle();
      chk("rel_gap_busy", 8'(release_busy), 8'd1);
      cyc(0, 1, 0, 0, 0, 0);
      chk("rel_rti_tmp", 8'(tmp_state), (k < 4) ? 8'd1 : 8'd0);
      chk("rel_rti_busy", 8'(release_busy), (k < 4) ? 8'd1 : 8'd0);
    end

    // Escape absorbs Test-Logic-Reset; without it TMP turns off
    go_on();
    for (int k = 0; k < 5; k++) begin
      cyc(1, 0, 0, 0, 0, 1);
      chk("esc_tmp", 8'(tmp_state), 8'd1);
    end
    chk("esc_used", 8'(escape_used), 8'd1);
    idle();
    chk("esc_sticky", 8'(escape_used), 8'd1);
    cyc(1, 0, 0, 0, 0, 0);
    chk("noesc_tmp", 8'(tmp_state), 8'd0);
    chk("noesc_used", 8'(escape_used), 8'd0);

    // Abort a release at count 2, then a fresh release takes the full 4
    go_on();
    cyc(0, 0, 1, 0, 1, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("abort_cnt2", u_dut.r_count, 8'd2);
    cyc(0, 0, 1, 1, 0, 0);
    chk("abort_tmp", 8'(tmp_state), 8'd1);
    chk("abort_busy", 8'(release_busy), 8'd0);
    chk("abort_cnt0", u_dut.r_count, 8'd0);
    cyc(0, 0, 1, 0, 1, 0);
    for (int k = 1; k <= 4; k++) begin
      cyc(0, 1, 0, 0, 0, 0);
      chk("rerel_tmp", 8'(tmp_state), (k < 4) ? 8'd1 : 8'd0);
    end

    // Asynchronous reset mid-release with escape_used set
    go_on();
    cyc(1, 0, 0, 0, 0, 1);
    chk("pre_rst_esc", 8'(escape_used), 8'd1);
    cyc(0, 0, 1, 0, 1, 0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("pre_rst_busy", 8'(release_busy), 8'd1);
    #2 TRST = 1'b0;
    #1;
    chk("arst_tmp", 8'(tmp_state), 8'd0);
    chk("arst_busy", 8'(release_busy), 8'd0);
    chk("arst_esc", 8'(escape_used), 8'd0);
    chk("arst_cnt", u_dut.r_count, 8'd0);
    @(negedge TCK);
    TRST = 1'b1;
    @(posedge TCK); #1;
    cyc(0, 1, 0, 0, 0, 0);
    chk("post_rst_off", 8'(tmp_state), 8'd0);

    // RELEASE_CYCLES=1: one Run-Test/Idle ends the release
    go_on();
    chk("b1_on", 8'(tmp_state1), 8'd1);
    cyc(0, 0, 1, 1, 1, 0);
    chk("both_sel_on_busy", 8'(release_busy1), 8'd0);
    chk("both_sel_on_tmp", 8'(tmp_state1), 8'd1);
    cyc(0, 0, 1, 0, 1, 0);
    chk("b1_rel_busy", 8'(release_busy1), 8'd1);
    cyc(0, 1, 0, 0, 0, 0);
    chk("b1_off_tmp", 8'(tmp_state1), 8'd0);
    chk("b1_off_busy", 8'(release_busy1), 8'd0);
    chk("b4_still_busy", 8'(release_busy), 8'd1);

    // Both select lines on update_ir while releasing returns to ON
    go_on();
    cyc(0, 0, 1, 0, 1, 0);
    chk("b1_rel2_busy", 8'(release_busy1), 8'd1);
    cyc(0, 0, 1, 1, 1, 0);
    chk("both_sel_rel_tmp", 8'(tmp_state1), 8'd1);
    chk("both_sel_rel_busy", 8'(release_busy1), 8'd0);
    chk("both_sel_rel_busy4", 8'(release_busy), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_tmp_controller

// File: doc/tmp_controller.md
TMP_CONTROLLER -- requirements
Module: tmp_controller

Interface
REQ-001 Parameter: RELEASE_CYCLES, default 4, Run-Test/Idle TCK cycles spent in release before TMP turns off; legal range 1..255.
REQ-002 Port: TCK  input  1  JTAG clock; the block's only clock.
REQ-003 Port: TRST  input  1  JTAG reset; asynchronous, active-low.
REQ-004 Port: test_logic_reset  input  1  TAP controller is in Test-Logic-Reset this cycle.
REQ-005 Port: run_test_idle  input  1  TAP controller is in Run-Test/Idle this cycle.
REQ-006 Port: update_ir  input  1  TAP controller is in Update-IR this cycle.
REQ-007 Port: clamp_hold_sel  input  1  IR decode: CLAMP_HOLD is being loaded.
REQ-008 Port: clamp_release_sel  input  1  IR decode: CLAMP_RELEASE is being loaded.
REQ-009 Port: bypass_escape  input  1  Escape bit from the TMP status register; 1 keeps TMP on through Test-Logic-Reset.
REQ-010 Port: tmp_state  output  1  TMP on (1) / off (0); feeds capture of the TMP status register.
REQ-011 Port: release_busy  output  1  Release countdown in progress.
REQ-012 Port: escape_used  output  1  Sticky flag: a Test-Logic-Reset was absorbed by bypass_escape.

Function
REQ-013 FSM states: OFF, ARMED, ON, RELEASING; all transitions on posedge TCK.
REQ-014 Event priority in every state: test_logic_reset > update_ir > run_test_idle.
REQ-015 OFF: update_ir & clamp_hold_sel -> ARMED; otherwise stay in OFF.
REQ-016 ARMED: test_logic_reset -> OFF; update_ir & !clamp_hold_sel -> OFF; run_test_idle -> ON; otherwise stay in ARMED.
REQ-017 ON: test_logic_reset & !bypass_escape -> OFF; test_logic_reset & bypass_escape -> stay in ON and set escape_used; update_ir & clamp_release_sel -> RELEASING with counter cleared to 0; otherwise stay in ON.
REQ-018 RELEASING: test_logic_reset -> OFF, regardless of bypass_escape; update_ir & clamp_hold_sel -> ON with counter cleared; run_test_idle & count==RELEASE_CYCLES-1 -> OFF; run_test_idle otherwise -> count+1; all other cycles hold the count.
REQ-019 Counter: 8 bits unsigned; never wraps, because the exit at RELEASE_CYCLES-1 precedes overflow; holds 0 outside RELEASING.
REQ-020 tmp_state = 1 iff state in {ON, RELEASING}; Moore output decoded from the state register; no combinational path from inputs.
REQ-021 release_busy = 1 iff state == RELEASING.
REQ-022 escape_used: set per REQ-017; cleared on any entry to OFF; unaffected by other transitions.
REQ-023 Simultaneous clamp_hold_sel and clamp_release_sel on update_ir: treated as clamp_hold_sel only, so ON stays ON and RELEASING returns to ON.
REQ-024 Latency: tmp_state rises on the first TCK edge after the first run_test_idle cycle in ARMED; it falls on the edge that consumes the RELEASE_CYCLES-th run_test_idle cycle in RELEASING.

Reset
REQ-025 TRST low asynchronously forces state = OFF, counter = 0, tmp_state = 0, release_busy = 0, escape_used = 0, including mid-release or mid-escape.
REQ-026 After TRST deasserts, the first transition occurs on the next posedge TCK.

Structure
REQ-027 Shared package tmp_pkg holds: the state enum (OFF, ARMED, ON, RELEASING), the counter width constant (8), and the RELEASE_CYCLES default.
REQ-028 Single flat module with one state/counter register block and one next-state combinational block; no sub-module.

Verification
REQ-029 Hold entry, RELEASE_CYCLES=4: update_ir+clamp_hold_sel, then 1 run_test_idle -> ARMED, then tmp_state=1 one edge later.
REQ-030 Release: from ON, update_ir+clamp_release_sel, then 4 run_test_idle cycles separated by 2 idle-less cycles -> release_busy=1 throughout; tmp_state=0 exactly after the 4th run_test_idle.
REQ-031 Escape: ON, bypass_escape=1, test_logic_reset for 5 cycles -> tmp_state stays 1, escape_used=1; repeat with bypass_escape=0 -> OFF, escape_used=0.
REQ-032 Abort release: RELEASING at count=2, update_ir+clamp_hold_sel -> ON; counter=0; a later release again takes 4 run_test_idle cycles.
REQ-033 Async reset: TRST low mid-RELEASING, between edges -> all outputs 0 immediately; state OFF after release.
REQ-034 Boundary: RELEASE_CYCLES=1, single run_test_idle in RELEASING -> OFF; both select lines asserted on update_ir in RELEASING -> ON.
